// File: rtl/pe_pkg.sv
// Shared types and default sizing for the row-convolution processing element.
package pe_pkg;

  // Controller phases: accept beats, multiply-accumulate, then hand results out.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CONV  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_FILT_LEN = 3;
  localparam int DEF_IMAP_LEN = 5;

  // Width of an index into an array of n entries (at least one bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pe_mac.sv
// Combinational multiply-accumulate: sum = acc + a*b, wrapped to DATA_W bits.
module pe_mac #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum
);

  // All operands and the result share DATA_W, so the product and the sum
  // are both evaluated modulo 2^DATA_W.
  assign sum = acc + a * b;

endmodule

// File: rtl/pe_row_conv.sv
// One-row 1-D convolution PE: loads weights/imap/psum over a beat stream,
// runs one MAC per cycle, then streams OUT_LEN results out with backpressure.
module pe_row_conv
  import pe_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int FILT_LEN = DEF_FILT_LEN,
  parameter int IMAP_LEN = DEF_IMAP_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_keep_w,
  input  logic [DATA_W-1:0] in_weight,
  input  logic [DATA_W-1:0] in_imap,
  input  logic [DATA_W-1:0] in_psum,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_psum,
  output logic              done
);

  localparam int OUT_LEN = IMAP_LEN - FILT_LEN + 1;
  localparam int IW      = idx_w(IMAP_LEN);
  localparam int FW      = idx_w(FILT_LEN);
  localparam int OW      = idx_w(OUT_LEN);

  localparam logic [IW-1:0] LAST_BEAT = IW'(IMAP_LEN - 1);
  localparam logic [FW-1:0] LAST_TAP  = FW'(FILT_LEN - 1);
  localparam logic [OW-1:0] LAST_OUT  = OW'(OUT_LEN - 1);

  state_t state, next_state;

  logic [DATA_W-1:0] weight_mem [FILT_LEN];
  logic [DATA_W-1:0] imap_mem   [IMAP_LEN];
  logic [DATA_W-1:0] psum_mem   [OUT_LEN];

  logic [IW-1:0] beat_cnt;
  logic [FW-1:0] tap_cnt;
  logic [OW-1:0] out_idx;
  logic [OW-1:0] drain_idx;
  logic          keep_r;
  logic          weights_loaded;

  logic              beat;
  logic              keep_now;
  logic              last_beat;
  logic              tap_last;
  logic              conv_last;
  logic              drain_fire;
  logic              drain_last;
  logic [IW-1:0]     imap_idx;
  logic [DATA_W-1:0] mac_sum;

  // Handshake and sequencing terms derived from state only, so the output
  // decode below never feeds back into itself.
  assign beat       = in_valid & ((state == IDLE) | (state == LOAD));
  assign last_beat  = (beat_cnt == LAST_BEAT);
  assign tap_last   = (tap_cnt == LAST_TAP);
  assign conv_last  = (state == CONV) & tap_last & (out_idx == LAST_OUT);
  assign drain_fire = (state == DRAIN) & out_ready;
  assign drain_last = (drain_idx == LAST_OUT);
  assign imap_idx   = IW'(out_idx) + IW'(tap_cnt);

  // Keep mode is decided on beat 0 and held for the rest of the job.
  assign keep_now = (beat_cnt == '0) ? (in_keep_w & weights_loaded) : keep_r;

  pe_mac #(
    .DATA_W(DATA_W)
  ) u_mac (
    .acc(psum_mem[out_idx]),
    .a  (weight_mem[tap_cnt]),
    .b  (imap_mem[imap_idx]),
    .sum(mac_sum)
  );

  // State register.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and output decode.
  // NOTE: every signal written here gets a default first, otherwise a path
  // that skips the assignment would infer a latch.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_psum   = '0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (beat) next_state = last_beat ? CONV : LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        if (beat && last_beat) next_state = CONV;
      end
      CONV: begin
        if (conv_last) next_state = DRAIN;
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_psum  = psum_mem[drain_idx];
        if (drain_fire && drain_last) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Beat capture, in-place accumulation, counters and the done pulse.
  // NOTE: the storage arrays are reset explicitly so an abandoned job leaves
  // nothing behind; this keeps them in flops rather than RAM macros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt       <= '0;
      tap_cnt        <= '0;
      out_idx        <= '0;
      drain_idx      <= '0;
      keep_r         <= 1'b0;
      weights_loaded <= 1'b0;
      done           <= 1'b0;
      for (int i = 0; i < FILT_LEN; i++) weight_mem[i] <= '0;
      for (int i = 0; i < IMAP_LEN; i++) imap_mem[i]   <= '0;
      for (int i = 0; i < OUT_LEN; i++)  psum_mem[i]   <= '0;
    end else begin
      done <= drain_fire & drain_last;

      if (beat) begin
        imap_mem[beat_cnt] <= in_imap;
        if (int'(beat_cnt) < OUT_LEN) psum_mem[beat_cnt[OW-1:0]] <= in_psum;
        if ((int'(beat_cnt) < FILT_LEN) && !keep_now)
          weight_mem[beat_cnt[FW-1:0]] <= in_weight;
        if (beat_cnt == '0) keep_r <= keep_now;
        if (last_beat) begin
          beat_cnt <= '0;
          if (!keep_now) weights_loaded <= 1'b1;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end

      if (state == CONV) begin
        psum_mem[out_idx] <= mac_sum;
        if (tap_last) begin
          tap_cnt <= '0;
          out_idx <= conv_last ? '0 : out_idx + 1'b1;
        end else begin
          tap_cnt <= tap_cnt + 1'b1;
        end
      end

      if (drain_fire) drain_idx <= drain_last ? '0 : drain_idx + 1'b1;
    end
  end

endmodule
